// File: rtl/trigger_ctrl_pkg.sv
// Shared types and constants for the trigger run controller: FSM states,
// return targets, register addresses and reset defaults.
package trigger_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        APPLY   = 3'd1,
        RUNNING = 3'd2,
        DRAIN   = 3'd3
    } state_t;

    // Where the FSM goes once the current apply or drain completes
    typedef enum logic [1:0] {
        RET_IDLE      = 2'd0,
        RET_RUN       = 2'd1,
        RET_APPLY_RUN = 2'd2
    } ret_t;

    localparam logic [2:0] ADDR_RISING_THR  = 3'd0;
    localparam logic [2:0] ADDR_FALLING_THR = 3'd1;
    localparam logic [2:0] ADDR_PRE_LEN     = 3'd2;
    localparam logic [2:0] ADDR_POST_LEN    = 3'd3;
    localparam logic [2:0] ADDR_SEL_PERIOD  = 3'd4;

    localparam int unsigned DEF_FALLING_THR = 0;
    localparam int unsigned DEF_PRE_LEN     = 0;
    localparam int unsigned DEF_POST_LEN    = 0;
    localparam int unsigned DEF_SEL_PERIOD  = 0;

    // Largest positive threshold for the given ADC resolution
    function automatic int unsigned rising_default(input int unsigned adc_res_width);
        return (32'd1 << (adc_res_width - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/trigger_cfg_regs.sv
// Shadow/active trigger settings bank. Shadow is written by the config strobe;
// active is loaded from shadow on apply_load. cfg_valid_c checks the shadow.
module trigger_cfg_regs
    import trigger_ctrl_pkg::*;
#(
    parameter  int unsigned ADC_RES_WIDTH                   = 12,
    parameter  int unsigned MAX_PRE_ACQUISITION_LENGTH      = 2,
    parameter  int unsigned MAX_POST_ACQUISITION_LENGTH     = 2,
    parameter  int unsigned MAX_ADC_SELECTION_PERIOD_LENGTH = 4,
    localparam int unsigned THR_W  = ADC_RES_WIDTH + 1,
    localparam int unsigned PRE_W  = $clog2(MAX_PRE_ACQUISITION_LENGTH),
    localparam int unsigned POST_W = $clog2(MAX_POST_ACQUISITION_LENGTH),
    localparam int unsigned SEL_W  = $clog2(MAX_ADC_SELECTION_PERIOD_LENGTH)
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic                    cfg_wr,
    input  logic [2:0]              cfg_addr,
    input  logic [15:0]             cfg_wdata,
    input  logic                    apply_load,
    output logic signed [THR_W-1:0] rising_thr,
    output logic signed [THR_W-1:0] falling_thr,
    output logic [PRE_W-1:0]        pre_len,
    output logic [POST_W-1:0]       post_len,
    output logic [SEL_W-1:0]        sel_len,
    output logic                    addr_err,
    output logic                    cfg_valid_c
);

    localparam logic signed [THR_W-1:0] RISING_DEF  = THR_W'(rising_default(ADC_RES_WIDTH));
    localparam logic signed [THR_W-1:0] FALLING_DEF = THR_W'(DEF_FALLING_THR);
    localparam logic [PRE_W-1:0]        PRE_DEF     = PRE_W'(DEF_PRE_LEN);
    localparam logic [POST_W-1:0]       POST_DEF    = POST_W'(DEF_POST_LEN);
    localparam logic [SEL_W-1:0]        SEL_DEF     = SEL_W'(DEF_SEL_PERIOD);

    logic signed [THR_W-1:0] sh_rising;
    logic signed [THR_W-1:0] sh_falling;
    logic [PRE_W-1:0]        sh_pre;
    logic [POST_W-1:0]       sh_post;
    logic [SEL_W-1:0]        sh_sel;

    // Upper write-data bits are don't-care by definition
    logic unused_wdata;
    assign unused_wdata = ^cfg_wdata[15:THR_W];

    // Shadow bank and sticky bad-address flag
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            sh_rising  <= RISING_DEF;
            sh_falling <= FALLING_DEF;
            sh_pre     <= PRE_DEF;
            sh_post    <= POST_DEF;
            sh_sel     <= SEL_DEF;
            addr_err   <= 1'b0;
        end else if (cfg_wr) begin
            case (cfg_addr)
                ADDR_RISING_THR:  sh_rising  <= THR_W'(cfg_wdata);
                ADDR_FALLING_THR: sh_falling <= THR_W'(cfg_wdata);
                ADDR_PRE_LEN:     sh_pre     <= PRE_W'(cfg_wdata);
                ADDR_POST_LEN:    sh_post    <= POST_W'(cfg_wdata);
                ADDR_SEL_PERIOD:  sh_sel     <= SEL_W'(cfg_wdata);
                default:          addr_err   <= 1'b1;
            endcase
        end
    end

    // Active bank; a same-cycle write lands in shadow only
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rising_thr  <= RISING_DEF;
            falling_thr <= FALLING_DEF;
            pre_len     <= PRE_DEF;
            post_len    <= POST_DEF;
            sel_len     <= SEL_DEF;
        end else if (apply_load) begin
            rising_thr  <= sh_rising;
            falling_thr <= sh_falling;
            pre_len     <= sh_pre;
            post_len    <= sh_post;
            sel_len     <= sh_sel;
        end
    end

    always_comb begin
        cfg_valid_c = 1'b1;
        if (sh_rising <= sh_falling)
            cfg_valid_c = 1'b0;
        if (32'(sh_pre) >= MAX_PRE_ACQUISITION_LENGTH)
            cfg_valid_c = 1'b0;
        if (32'(sh_post) >= MAX_POST_ACQUISITION_LENGTH)
            cfg_valid_c = 1'b0;
        if (32'(sh_sel) >= MAX_ADC_SELECTION_PERIOD_LENGTH)
            cfg_valid_c = 1'b0;
    end

endmodule

// File: rtl/trigger_run_controller.sv
// Run-control sequencer for one trigger_core channel: gates STOP, applies
// shadow settings while the core is quiescent and counts trigger windows.
module trigger_run_controller
    import trigger_ctrl_pkg::*;
#(
    parameter  int unsigned ADC_RES_WIDTH                   = 12,
    parameter  int unsigned MAX_PRE_ACQUISITION_LENGTH      = 2,
    parameter  int unsigned MAX_POST_ACQUISITION_LENGTH     = 2,
    parameter  int unsigned MAX_ADC_SELECTION_PERIOD_LENGTH = 4,
    parameter  int unsigned APPLY_CYCLES                    = 2,
    parameter  int unsigned DRAIN_TIMEOUT                   = 1024,
    localparam int unsigned THR_W  = ADC_RES_WIDTH + 1,
    localparam int unsigned PRE_W  = $clog2(MAX_PRE_ACQUISITION_LENGTH),
    localparam int unsigned POST_W = $clog2(MAX_POST_ACQUISITION_LENGTH),
    localparam int unsigned SEL_W  = $clog2(MAX_ADC_SELECTION_PERIOD_LENGTH)
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic                    CFG_WR,
    input  logic [2:0]              CFG_ADDR,
    input  logic [15:0]             CFG_WDATA,
    input  logic                    CMD_START,
    input  logic                    CMD_STOP,
    input  logic                    CMD_APPLY,
    input  logic                    TRIGGER_IN,
    output logic                    SET_CONFIG,
    output logic                    STOP,
    output logic signed [THR_W-1:0] RISING_EDGE_THRESHOLD,
    output logic signed [THR_W-1:0] FALLING_EDGE_THRESHOLD,
    output logic [PRE_W-1:0]        PRE_ACQUISITION_LENGTH,
    output logic [POST_W-1:0]       POST_ACQUISITION_LENGTH,
    output logic [SEL_W-1:0]        ADC_SELECTION_PERIOD_LENGTH,
    output logic [2:0]              STATE,
    output logic [31:0]             TRIGGER_COUNT,
    output logic                    CFG_ERR,
    output logic                    ADDR_ERR,
    output logic                    TIMEOUT_FLAG
);

    localparam int unsigned CW = $clog2(APPLY_CYCLES + 1);
    localparam int unsigned DW = $clog2(DRAIN_TIMEOUT + 1);

    state_t          state_q, state_d;
    ret_t            ret_q, ret_d;
    logic [CW-1:0]   apply_cnt_q, apply_cnt_d;
    logic [DW-1:0]   drain_cnt_q, drain_cnt_d;
    logic            trig_q;
    logic [31:0]     count_d;
    logic            cfg_err_d, timeout_d;
    logic            stop_d, set_cfg_d;
    logic            apply_load, cfg_valid_c;
    logic            go_apply, clr_count, drain_done;
    ret_t            apply_ret, ret_eff;

    trigger_cfg_regs #(
        .ADC_RES_WIDTH                   (ADC_RES_WIDTH),
        .MAX_PRE_ACQUISITION_LENGTH      (MAX_PRE_ACQUISITION_LENGTH),
        .MAX_POST_ACQUISITION_LENGTH     (MAX_POST_ACQUISITION_LENGTH),
        .MAX_ADC_SELECTION_PERIOD_LENGTH (MAX_ADC_SELECTION_PERIOD_LENGTH)
    ) u_cfg_regs (
        .ACLK        (ACLK),
        .ARESETN     (ARESETN),
        .cfg_wr      (CFG_WR),
        .cfg_addr    (CFG_ADDR),
        .cfg_wdata   (CFG_WDATA),
        .apply_load  (apply_load),
        .rising_thr  (RISING_EDGE_THRESHOLD),
        .falling_thr (FALLING_EDGE_THRESHOLD),
        .pre_len     (PRE_ACQUISITION_LENGTH),
        .post_len    (POST_ACQUISITION_LENGTH),
        .sel_len     (ADC_SELECTION_PERIOD_LENGTH),
        .addr_err    (ADDR_ERR),
        .cfg_valid_c (cfg_valid_c)
    );

    assign STATE = state_q;

    // State, timers, counter and registered outputs
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q       <= IDLE;
            ret_q         <= RET_IDLE;
            apply_cnt_q   <= '0;
            drain_cnt_q   <= '0;
            trig_q        <= 1'b0;
            TRIGGER_COUNT <= '0;
            CFG_ERR       <= 1'b0;
            TIMEOUT_FLAG  <= 1'b0;
            STOP          <= 1'b1;
            SET_CONFIG    <= 1'b0;
        end else begin
            state_q       <= state_d;
            ret_q         <= ret_d;
            apply_cnt_q   <= apply_cnt_d;
            drain_cnt_q   <= drain_cnt_d;
            trig_q        <= TRIGGER_IN;
            TRIGGER_COUNT <= count_d;
            CFG_ERR       <= cfg_err_d;
            TIMEOUT_FLAG  <= timeout_d;
            STOP          <= stop_d;
            SET_CONFIG    <= set_cfg_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        apply_cnt_d = apply_cnt_q;
        drain_cnt_d = drain_cnt_q;
        cfg_err_d   = CFG_ERR;
        timeout_d   = TIMEOUT_FLAG;
        apply_load  = 1'b0;
        go_apply    = 1'b0;
        apply_ret   = RET_IDLE;
        clr_count   = 1'b0;
        drain_done  = 1'b0;
        ret_eff     = ret_q;

        case (state_q)
            IDLE: begin
                if (!CMD_STOP) begin
                    if (CMD_APPLY) begin
                        go_apply  = 1'b1;
                        apply_ret = RET_IDLE;
                    end else if (CMD_START) begin
                        go_apply  = 1'b1;
                        apply_ret = RET_RUN;
                        clr_count = 1'b1;
                    end
                end
            end
            APPLY: begin
                if (apply_cnt_q == '0)
                    state_d = (ret_q == RET_RUN) ? RUNNING : IDLE;
                else
                    apply_cnt_d = apply_cnt_q - CW'(1);
            end
            RUNNING: begin
                if (CMD_STOP || CMD_APPLY) begin
                    state_d     = DRAIN;
                    ret_d       = CMD_STOP ? RET_IDLE : RET_APPLY_RUN;
                    drain_cnt_d = '0;
                end
            end
            DRAIN: begin
                ret_eff = CMD_STOP ? RET_IDLE : ret_q;
                ret_d   = ret_eff;
                if (!TRIGGER_IN) begin
                    drain_done = 1'b1;
                end else if (drain_cnt_q == DW'(DRAIN_TIMEOUT - 1)) begin
                    drain_done = 1'b1;
                    timeout_d  = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + DW'(1);
                end
                if (drain_done) begin
                    if (ret_eff == RET_APPLY_RUN) begin
                        go_apply  = 1'b1;
                        apply_ret = RET_RUN;
                    end else begin
                        state_d = IDLE;
                        ret_d   = RET_IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                ret_d   = RET_IDLE;
            end
        endcase

        // Validation and the shadow->active copy happen on the APPLY entry edge;
        // a rejected setting never enters APPLY, so no SET_CONFIG pulse is seen
        if (go_apply) begin
            if (cfg_valid_c) begin
                state_d     = APPLY;
                ret_d       = apply_ret;
                apply_load  = 1'b1;
                apply_cnt_d = CW'(APPLY_CYCLES - 1);
                cfg_err_d   = 1'b0;
            end else begin
                state_d   = IDLE;
                ret_d     = RET_IDLE;
                cfg_err_d = 1'b1;
            end
        end

        count_d = TRIGGER_COUNT;
        if (clr_count)
            count_d = '0;
        else if (state_q == RUNNING && TRIGGER_IN && !trig_q && TRIGGER_COUNT != '1)
            count_d = TRIGGER_COUNT + 32'd1;

        stop_d    = (state_d != RUNNING);
        set_cfg_d = (state_d == APPLY);
    end

endmodule

// File: tb/tb_trigger_run_controller.sv
// Directed bench for trigger_run_controller with hand-computed expectations.
module tb_trigger_run_controller;

    logic               ACLK = 1'b0;
    logic               ARESETN = 1'b0;
    logic               CFG_WR = 1'b0;
    logic [2:0]         CFG_ADDR = 3'd0;
    logic [15:0]        CFG_WDATA = 16'd0;
    logic               CMD_START = 1'b0;
    logic               CMD_STOP = 1'b0;
    logic               CMD_APPLY = 1'b0;
    logic               TRIGGER_IN = 1'b0;
    logic               SET_CONFIG, STOP;
    logic signed [12:0] RISING_EDGE_THRESHOLD, FALLING_EDGE_THRESHOLD;
    logic [0:0]         PRE_ACQUISITION_LENGTH, POST_ACQUISITION_LENGTH;
    logic [1:0]         ADC_SELECTION_PERIOD_LENGTH;
    logic [2:0]         STATE;
    logic [31:0]        TRIGGER_COUNT;
    logic               CFG_ERR, ADDR_ERR, TIMEOUT_FLAG;

    int total = 0;
    int bad = 0;

    trigger_run_controller #(.DRAIN_TIMEOUT(16)) dut (
        .ACLK                        (ACLK),
        .ARESETN                     (ARESETN),
        .CFG_WR                      (CFG_WR),
        .CFG_ADDR                    (CFG_ADDR),
        .CFG_WDATA                   (CFG_WDATA),
        .CMD_START                   (CMD_START),
        .CMD_STOP                    (CMD_STOP),
        .CMD_APPLY                   (CMD_APPLY),
        .TRIGGER_IN                  (TRIGGER_IN),
        .SET_CONFIG                  (SET_CONFIG),
        .STOP                        (STOP),
        .RISING_EDGE_THRESHOLD       (RISING_EDGE_THRESHOLD),
        .FALLING_EDGE_THRESHOLD      (FALLING_EDGE_THRESHOLD),
        .PRE_ACQUISITION_LENGTH      (PRE_ACQUISITION_LENGTH),
        .POST_ACQUISITION_LENGTH     (POST_ACQUISITION_LENGTH),
        .ADC_SELECTION_PERIOD_LENGTH (ADC_SELECTION_PERIOD_LENGTH),
        .STATE                       (STATE),
        .TRIGGER_COUNT               (TRIGGER_COUNT),
        .CFG_ERR                     (CFG_ERR),
        .ADDR_ERR                    (ADDR_ERR),
        .TIMEOUT_FLAG                (TIMEOUT_FLAG)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge ACLK);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        CFG_WR = 1'b1; CFG_ADDR = a; CFG_WDATA = d;
        cyc();
        CFG_WR = 1'b0;
    endtask

    task automatic do_start();
        CMD_START = 1'b1; cyc(); CMD_START = 1'b0;
        cyc(); cyc();
    endtask

    task automatic go_idle();
        TRIGGER_IN = 1'b0;
        CMD_STOP = 1'b1; cyc(); CMD_STOP = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        ARESETN = 1'b0;
        repeat (2) @(posedge ACLK);
        #1;
        total++; if (STATE !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", STATE); end
        total++; if (STOP !== 1'b1) begin bad++; $display("FAIL rst_stop got=%b exp=1", STOP); end
        total++; if (SET_CONFIG !== 1'b0) begin bad++; $display("FAIL rst_setcfg got=%b exp=0", SET_CONFIG); end
        total++; if (RISING_EDGE_THRESHOLD !== 13'd2047) begin bad++; $display("FAIL rst_rising got=%0d exp=2047", RISING_EDGE_THRESHOLD); end
        total++; if ({FALLING_EDGE_THRESHOLD, PRE_ACQUISITION_LENGTH, POST_ACQUISITION_LENGTH, ADC_SELECTION_PERIOD_LENGTH} !== 17'd0)
            begin bad++; $display("FAIL rst_fields got=%h/%h/%h/%h exp=0", FALLING_EDGE_THRESHOLD, PRE_ACQUISITION_LENGTH, POST_ACQUISITION_LENGTH, ADC_SELECTION_PERIOD_LENGTH); end
        total++; if (TRIGGER_COUNT !== 32'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", TRIGGER_COUNT); end
        total++; if ({CFG_ERR, ADDR_ERR, TIMEOUT_FLAG} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b%b%b exp=000", CFG_ERR, ADDR_ERR, TIMEOUT_FLAG); end
        ARESETN = 1'b1;
        cyc();
    endtask

    task automatic test_start();
        wr(3'd0, 16'd100); wr(3'd1, 16'd20); wr(3'd2, 16'd1); wr(3'd3, 16'd1); wr(3'd4, 16'd2);
        total++; if (RISING_EDGE_THRESHOLD !== 13'd2047) begin bad++; $display("FAIL shadow_leak got=%0d exp=2047", RISING_EDGE_THRESHOLD); end
        wr(3'd6, 16'd55);
        total++; if (ADDR_ERR !== 1'b1) begin bad++; $display("FAIL addr_err got=%b exp=1", ADDR_ERR); end
        CMD_START = 1'b1; cyc(); CMD_START = 1'b0;
        total++; if (STATE !== 3'd1) begin bad++; $display("FAIL start_state1 got=%0d exp=1", STATE); end
        total++; if ({SET_CONFIG, STOP} !== 2'b11) begin bad++; $display("FAIL start_c1 setcfg/stop got=%b%b exp=11", SET_CONFIG, STOP); end
        total++; if (RISING_EDGE_THRESHOLD !== 13'd100 || FALLING_EDGE_THRESHOLD !== 13'd20) begin bad++;
            $display("FAIL start_thr got=%0d/%0d exp=100/20", RISING_EDGE_THRESHOLD, FALLING_EDGE_THRESHOLD); end
        total++; if ({PRE_ACQUISITION_LENGTH, POST_ACQUISITION_LENGTH, ADC_SELECTION_PERIOD_LENGTH} !== 4'b1110) begin bad++;
            $display("FAIL start_len got=%0d/%0d/%0d exp=1/1/2", PRE_ACQUISITION_LENGTH, POST_ACQUISITION_LENGTH, ADC_SELECTION_PERIOD_LENGTH); end
        cyc();
        total++; if ({SET_CONFIG, STOP} !== 2'b11) begin bad++; $display("FAIL start_c2 setcfg/stop got=%b%b exp=11", SET_CONFIG, STOP); end
        cyc();
        total++; if ({SET_CONFIG, STOP} !== 2'b00) begin bad++; $display("FAIL start_c3 setcfg/stop got=%b%b exp=00", SET_CONFIG, STOP); end
        total++; if (STATE !== 3'd2) begin bad++; $display("FAIL start_run got=%0d exp=2", STATE); end
    endtask

    task automatic test_count();
        for (int i = 0; i < 4; i++) begin
            TRIGGER_IN = 1'b1; cyc(); TRIGGER_IN = 1'b0; cyc();
        end
        TRIGGER_IN = 1'b1; cyc();
        total++; if (TRIGGER_COUNT !== 32'd5) begin bad++; $display("FAIL count5 got=%0d exp=5", TRIGGER_COUNT); end
        CMD_STOP = 1'b1; cyc(); CMD_STOP = 1'b0;
        total++; if (STOP !== 1'b1 || STATE !== 3'd3) begin bad++; $display("FAIL stop_drain stop=%b state=%0d exp=1/3", STOP, STATE); end
        repeat (9) cyc();
        total++; if (STATE !== 3'd3) begin bad++; $display("FAIL drain_hold got=%0d exp=3", STATE); end
        TRIGGER_IN = 1'b0; cyc();
        total++; if (STATE !== 3'd0) begin bad++; $display("FAIL drain_exit got=%0d exp=0", STATE); end
        total++; if (TRIGGER_COUNT !== 32'd5) begin bad++; $display("FAIL count_hold got=%0d exp=5", TRIGGER_COUNT); end
        total++; if (TIMEOUT_FLAG !== 1'b0) begin bad++; $display("FAIL no_timeout got=%b exp=0", TIMEOUT_FLAG); end
    endtask

    task automatic test_apply_run();
        do_start();
        total++; if (TRIGGER_COUNT !== 32'd0) begin bad++; $display("FAIL start_clr got=%0d exp=0", TRIGGER_COUNT); end
        for (int i = 0; i < 3; i++) begin
            TRIGGER_IN = 1'b1; cyc(); TRIGGER_IN = 1'b0; cyc();
        end
        wr(3'd0, 16'd200);
        CMD_APPLY = 1'b1; cyc(); CMD_APPLY = 1'b0;
        total++; if (STATE !== 3'd3 || STOP !== 1'b1) begin bad++; $display("FAIL ar_drain state=%0d stop=%b exp=3/1", STATE, STOP); end
        cyc();
        total++; if (STATE !== 3'd1 || SET_CONFIG !== 1'b1) begin bad++; $display("FAIL ar_apply state=%0d setcfg=%b exp=1/1", STATE, SET_CONFIG); end
        total++; if (RISING_EDGE_THRESHOLD !== 13'd200) begin bad++; $display("FAIL ar_rising got=%0d exp=200", RISING_EDGE_THRESHOLD); end
        cyc();
        total++; if (SET_CONFIG !== 1'b1) begin bad++; $display("FAIL ar_setcfg2 got=%b exp=1", SET_CONFIG); end
        cyc();
        total++; if (STATE !== 3'd2 || STOP !== 1'b0 || SET_CONFIG !== 1'b0) begin bad++;
            $display("FAIL ar_run state=%0d stop=%b setcfg=%b exp=2/0/0", STATE, STOP, SET_CONFIG); end
        total++; if (TRIGGER_COUNT !== 32'd3) begin bad++; $display("FAIL ar_count got=%0d exp=3", TRIGGER_COUNT); end
    endtask

    task automatic test_invalid();
        go_idle();
        wr(3'd0, 16'd20); wr(3'd1, 16'd20);
        CMD_START = 1'b1; cyc(); CMD_START = 1'b0;
        total++; if (CFG_ERR !== 1'b1) begin bad++; $display("FAIL inv_err got=%b exp=1", CFG_ERR); end
        total++; if (STATE !== 3'd0 || SET_CONFIG !== 1'b0 || STOP !== 1'b1) begin bad++;
            $display("FAIL inv_state state=%0d setcfg=%b stop=%b exp=0/0/1", STATE, SET_CONFIG, STOP); end
        cyc();
        total++; if (SET_CONFIG !== 1'b0 || STOP !== 1'b1) begin bad++; $display("FAIL inv_quiet setcfg=%b stop=%b exp=0/1", SET_CONFIG, STOP); end
        total++; if (RISING_EDGE_THRESHOLD !== 13'd200 || FALLING_EDGE_THRESHOLD !== 13'd20) begin bad++;
            $display("FAIL inv_active got=%0d/%0d exp=200/20", RISING_EDGE_THRESHOLD, FALLING_EDGE_THRESHOLD); end
        // Signed thresholds: 5 > -3 must be accepted
        wr(3'd0, 16'd5); wr(3'd1, 16'hFFFD);
        CMD_APPLY = 1'b1; cyc(); CMD_APPLY = 1'b0;
        total++; if (CFG_ERR !== 1'b0 || STATE !== 3'd1) begin bad++; $display("FAIL sgn_apply err=%b state=%0d exp=0/1", CFG_ERR, STATE); end
        total++; if (FALLING_EDGE_THRESHOLD !== 13'h1FFD || RISING_EDGE_THRESHOLD !== 13'd5) begin bad++;
            $display("FAIL sgn_thr got=%h/%h exp=0005/1ffd", RISING_EDGE_THRESHOLD, FALLING_EDGE_THRESHOLD); end
        cyc(); cyc();
        total++; if (STATE !== 3'd0 || STOP !== 1'b1 || SET_CONFIG !== 1'b0) begin bad++;
            $display("FAIL sgn_idle state=%0d stop=%b setcfg=%b exp=0/1/0", STATE, STOP, SET_CONFIG); end
    endtask

    task automatic test_stop_apply_same();
        wr(3'd0, 16'd100); wr(3'd1, 16'd20);
        do_start();
        wr(3'd0, 16'd150);
        CMD_STOP = 1'b1; CMD_APPLY = 1'b1; cyc(); CMD_STOP = 1'b0; CMD_APPLY = 1'b0;
        total++; if (STATE !== 3'd3 || SET_CONFIG !== 1'b0) begin bad++; $display("FAIL sa_drain state=%0d setcfg=%b exp=3/0", STATE, SET_CONFIG); end
        cyc();
        total++; if (STATE !== 3'd0 || SET_CONFIG !== 1'b0) begin bad++; $display("FAIL sa_idle state=%0d setcfg=%b exp=0/0", STATE, SET_CONFIG); end
        total++; if (RISING_EDGE_THRESHOLD !== 13'd100) begin bad++; $display("FAIL sa_noapply got=%0d exp=100", RISING_EDGE_THRESHOLD); end
    endtask

    task automatic test_drain_retarget();
        do_start();
        wr(3'd0, 16'd175);
        TRIGGER_IN = 1'b1;
        CMD_APPLY = 1'b1; cyc(); CMD_APPLY = 1'b0;
        CMD_STOP = 1'b1; cyc(); CMD_STOP = 1'b0;
        total++; if (STATE !== 3'd3) begin bad++; $display("FAIL rt_drain got=%0d exp=3", STATE); end
        TRIGGER_IN = 1'b0; cyc();
        total++; if (STATE !== 3'd0 || RISING_EDGE_THRESHOLD !== 13'd150) begin bad++;
            $display("FAIL rt_idle state=%0d rising=%0d exp=0/150", STATE, RISING_EDGE_THRESHOLD); end
    endtask

    task automatic test_timeout();
        do_start();
        TRIGGER_IN = 1'b1; cyc();
        CMD_STOP = 1'b1; cyc(); CMD_STOP = 1'b0;
        repeat (15) cyc();
        total++; if (TIMEOUT_FLAG !== 1'b0 || STATE !== 3'd3) begin bad++; $display("FAIL to_early flag=%b state=%0d exp=0/3", TIMEOUT_FLAG, STATE); end
        cyc();
        total++; if (TIMEOUT_FLAG !== 1'b1 || STATE !== 3'd0) begin bad++; $display("FAIL to_fire flag=%b state=%0d exp=1/0", TIMEOUT_FLAG, STATE); end
        TRIGGER_IN = 1'b0; cyc();
        total++; if (TIMEOUT_FLAG !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b exp=1", TIMEOUT_FLAG); end
    endtask

    task automatic test_reset_mid_apply();
        CMD_START = 1'b1; cyc(); CMD_START = 1'b0;
        total++; if (SET_CONFIG !== 1'b1) begin bad++; $display("FAIL ma_setcfg got=%b exp=1", SET_CONFIG); end
        #2 ARESETN = 1'b0;
        #1;
        total++; if (SET_CONFIG !== 1'b0 || STOP !== 1'b1) begin bad++; $display("FAIL ma_async setcfg=%b stop=%b exp=0/1", SET_CONFIG, STOP); end
        total++; if (STATE !== 3'd0 || TIMEOUT_FLAG !== 1'b0 || ADDR_ERR !== 1'b0) begin bad++;
            $display("FAIL ma_clear state=%0d to=%b ae=%b exp=0/0/0", STATE, TIMEOUT_FLAG, ADDR_ERR); end
        total++; if (RISING_EDGE_THRESHOLD !== 13'd2047) begin bad++; $display("FAIL ma_rising got=%0d exp=2047", RISING_EDGE_THRESHOLD); end
        @(negedge ACLK) ARESETN = 1'b1;
        cyc();
        total++; if (STATE !== 3'd0 || STOP !== 1'b1) begin bad++; $display("FAIL ma_after state=%0d stop=%b exp=0/1", STATE, STOP); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_count();
        test_apply_run();
        test_invalid();
        test_stop_apply_same();
        test_drain_retarget();
        test_timeout();
        test_reset_mid_apply();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
